// File: rtl/decoder_grant_arbiter_pkg.sv
// Shared types and sizes for the four-way decoder grant arbiter.
package decoder_grant_arbiter_pkg;
    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int HOLD_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } arb_state_t;
endpackage

// File: rtl/decoder_grant_arbiter_rr_pick4.sv
// Combinational round-robin pick: first set request at or after ptr_i.
module rr_pick4
    import decoder_grant_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);
    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset back so the nearest match wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr_i + IDX_W'(k);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end
endmodule

// File: rtl/decoder_grant_arbiter.sv
// Round-robin owner of a 2-to-4 decoder: registered one-hot grant,
// select lines, hold timeout and one-cycle turnaround gap.
module decoder_grant_arbiter
    import decoder_grant_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   sel,
    output logic               busy,
    output logic               expired
);
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic TIMEOUT_EN = (MAX_HOLD != 0);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               busy_q, busy_d;
    logic               expired_q, expired_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               release_w;
    logic               timeout_w;

    rr_pick4 u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign release_w = ~req[idx_q];
    assign timeout_w = TIMEOUT_EN && (hold_q == HOLD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = GRANT;
            GRANT:   if (release_w || timeout_w) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        expired_d = 1'b0;
        busy_d    = (state_d == GRANT);
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    gnt_d[pick_idx] = 1'b1;
                    sel_d  = pick_idx;
                    idx_d  = pick_idx;
                    hold_d = '0;
                end
            end
            GRANT: begin
                if (release_w || timeout_w) begin
                    gnt_d = '0;
                    ptr_d = idx_q + IDX_W'(1);
                    // Release wins over a coincident timeout.
                    expired_d = ~release_w & timeout_w;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: gnt_d = '0;
        endcase
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign expired = expired_q;
endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Directed bench: rotation table on an untimed instance, timeout,
// release/timeout collision and async reset on a MAX_HOLD=4 instance.
module tb_decoder_grant_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req0, req4;
    logic [3:0] gnt0, gnt4;
    logic [1:0] sel0, sel4;
    logic       busy0, busy4, exp0, exp4;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    vec_t tv[$];

    always #5 clk = ~clk;

    decoder_grant_arbiter #(.MAX_HOLD(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .gnt(gnt0),
        .sel(sel0), .busy(busy0), .expired(exp0)
    );

    decoder_grant_arbiter #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .reset(reset), .req(req4), .gnt(gnt4),
        .sel(sel4), .busy(busy4), .expired(exp4)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic v(input logic [3:0] r, input logic [3:0] g,
                     input logic [1:0] s, input logic b);
        vec_t e;
        e.req  = r;
        e.gnt  = g;
        e.sel  = s;
        e.busy = b;
        tv.push_back(e);
    endtask

    initial begin
        // rotation 0,1,2,3,0 with two dead cycles after each release
        v(4'b1111, 4'b0001, 2'd0, 1); v(4'b1111, 4'b0001, 2'd0, 1);
        v(4'b1111, 4'b0001, 2'd0, 1); v(4'b1110, 4'b0000, 2'd0, 0);
        v(4'b1110, 4'b0000, 2'd0, 0); v(4'b1110, 4'b0010, 2'd1, 1);
        v(4'b1110, 4'b0010, 2'd1, 1); v(4'b1110, 4'b0010, 2'd1, 1);
        v(4'b1100, 4'b0000, 2'd1, 0); v(4'b1100, 4'b0000, 2'd1, 0);
        v(4'b1100, 4'b0100, 2'd2, 1); v(4'b1100, 4'b0100, 2'd2, 1);
        v(4'b1100, 4'b0100, 2'd2, 1); v(4'b1000, 4'b0000, 2'd2, 0);
        v(4'b1000, 4'b0000, 2'd2, 0); v(4'b1000, 4'b1000, 2'd3, 1);
        v(4'b1000, 4'b1000, 2'd3, 1); v(4'b1000, 4'b1000, 2'd3, 1);
        v(4'b0001, 4'b0000, 2'd3, 0); v(4'b0001, 4'b0000, 2'd3, 0);
        v(4'b0001, 4'b0001, 2'd0, 1); v(4'b0000, 4'b0000, 2'd0, 0);
        v(4'b0000, 4'b0000, 2'd0, 0);
        // grant 2 so ptr lands on 3, then wrap checks
        v(4'b0100, 4'b0100, 2'd2, 1); v(4'b0000, 4'b0000, 2'd2, 0);
        v(4'b0000, 4'b0000, 2'd2, 0); v(4'b0101, 4'b0001, 2'd0, 1);
        v(4'b0000, 4'b0000, 2'd0, 0); v(4'b0000, 4'b0000, 2'd0, 0);
        v(4'b0101, 4'b0100, 2'd2, 1); v(4'b0000, 4'b0000, 2'd2, 0);
        v(4'b0000, 4'b0000, 2'd2, 0);

        reset = 1'b1;
        req0  = 4'b1111;
        req4  = 4'b0000;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt0), 32'h0);
        chk("rst_sel", 32'(sel0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_exp", 32'(exp0), 32'h0);
        chk("rst_gnt4", 32'(gnt4), 32'h0);
        reset = 1'b0;

        foreach (tv[i]) begin
            req0 = tv[i].req;
            tick();
            chk($sformatf("v%0d_gnt", i), 32'(gnt0), 32'(tv[i].gnt));
            chk($sformatf("v%0d_sel", i), 32'(sel0), 32'(tv[i].sel));
            chk($sformatf("v%0d_busy", i), 32'(busy0), 32'(tv[i].busy));
            chk($sformatf("v%0d_exp", i), 32'(exp0), 32'h0);
        end

        // timeout: req[1] held, req[2] waiting
        req4 = 4'b0110;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("to_gnt%0d", c), 32'(gnt4), 32'h2);
            chk($sformatf("to_exp%0d", c), 32'(exp4), 32'h0);
        end
        tick();
        chk("to_gap_gnt", 32'(gnt4), 32'h0);
        chk("to_gap_exp", 32'(exp4), 32'h1);
        chk("to_gap_busy", 32'(busy4), 32'h0);
        tick();
        chk("to_idle_gnt", 32'(gnt4), 32'h0);
        chk("to_idle_exp", 32'(exp4), 32'h0);
        tick();
        chk("to_next_gnt", 32'(gnt4), 32'h4);
        chk("to_next_sel", 32'(sel4), 32'h2);

        // release on the timeout cycle: no expired pulse
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("rt_gnt%0d", c), 32'(gnt4), 32'h4);
        end
        req4 = 4'b0010;
        tick();
        chk("rt_gap_gnt", 32'(gnt4), 32'h0);
        chk("rt_gap_exp", 32'(exp4), 32'h0);
        chk("rt_gap_busy", 32'(busy4), 32'h0);
        tick();
        chk("rt_idle_exp", 32'(exp4), 32'h0);
        tick();
        chk("rt_wrap_gnt", 32'(gnt4), 32'h2);
        chk("rt_wrap_sel", 32'(sel4), 32'h1);
        chk("rt_wrap_busy", 32'(busy4), 32'h1);

        // async reset mid-grant, between edges
        #2;
        reset = 1'b1;
        #1;
        chk("ar_gnt", 32'(gnt4), 32'h0);
        chk("ar_busy", 32'(busy4), 32'h0);
        chk("ar_sel", 32'(sel4), 32'h0);
        tick();
        reset = 1'b0;
        req4  = 4'b1111;
        tick();
        chk("ar_ptr_gnt", 32'(gnt4), 32'h1);
        chk("ar_ptr_sel", 32'(sel4), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decoder_grant_arbiter.md
# decoder_grant_arbiter

Round-robin arbiter that shares one 2-to-4 decoder-driven resource among four requesters. It picks one requester, drives the decoder select lines with that requester's 2-bit index, and holds a registered one-hot grant until the requester releases or a hold timeout expires. It sits between the requesting blocks and the decoded resource and is the only driver of the decoder select inputs.

## Interface
- MAX_HOLD, 8: maximum consecutive GRANT cycles per tenure; 0 disables the timeout; legal range 0..255.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request vector; req[i] is held high for as long as requester i wants the resource.
- gnt  output  4  registered one-hot grant, or all zero.
- sel  output  2  decoder select (a = sel[1], b = sel[0]); equals the granted index and holds its last value while idle.
- busy  output  1  high while in GRANT.
- expired  output  1  one-cycle pulse when a tenure ends by timeout.

## Operation
- States: IDLE, GRANT, GAP. Encoding is 2 bits; the unused code returns to IDLE.
- IDLE:
  - gnt = 0.
  - If req != 0, pick the first i with req[i] = 1, searching ptr, ptr+1, … mod 4.
  - Register gnt = 1 << i, sel = i, idx = i, hold_cnt = 0, then go to GRANT.
  - If req = 0, stay in IDLE.
- GRANT:
  - gnt is held and hold_cnt increments each cycle (8-bit counter, saturating).
  - Release: if req[idx] = 0, go to GAP.
  - Timeout: if MAX_HOLD != 0, req[idx] = 1 and hold_cnt = MAX_HOLD-1, go to GAP and pulse expired.
  - Release takes priority over timeout when both occur in the same cycle; expired stays 0.
  - On exit, ptr <= idx+1 mod 4. Index 3 wraps to 0.
  - Requests from other requesters during GRANT are ignored and not latched.
- GAP:
  - gnt = 0 for exactly one turnaround cycle, then go to IDLE unconditionally.
- A preempted requester that keeps req high competes again normally and has lowest priority next round.
- The grant is not gated combinationally by req: gnt stays high during the cycle in which req[idx] falls.

## Timing
- Reset values: state = IDLE, gnt = 4'b0000, sel = 2'b00, busy = 0, expired = 0, ptr = 0, hold_cnt = 0.
- Reset assertion clears all outputs immediately (asynchronous), including mid-tenure. Deassertion is synchronous to clk.
- Grant latency: req sampled high in IDLE at edge N gives gnt high after edge N.
- Release latency: req[idx] sampled low at edge M gives gnt low after edge M. GAP lasts until edge M+1 and IDLE until M+2. The earliest next grant appears after edge M+2.
- Timeout: with MAX_HOLD = K, gnt is high for exactly K cycles. expired is high in the first GAP cycle.
- busy equals (state == GRANT) and is registered.

## Structure
- Shared package holds:
  - arb_state_t (IDLE, GRANT, GAP);
  - NUM_REQ = 4;
  - IDX_W = 2;
  - HOLD_W = 8.
- One sub-module, rr_pick4: combinational round-robin priority select from (req, ptr), producing (found, idx).
- The FSM, counter, pointer and output registers live in the top.

## Test plan
- Reset / idle: reset high with req = 4'b1111 gives gnt = 0 and sel = 0. After release, gnt = 4'b0001 one cycle later.
- Rotation: MAX_HOLD = 0, all four requesters hold req for 3 cycles each then drop. Grant order is 0, 1, 2, 3, 0. Each release is followed by 2 dead cycles.
- Wrap / pointer:
  - ptr = 3 (after granting 2), req = 4'b0101 gives the grant to 0 (wrap).
  - Then req = 4'b0101 again gives the grant to 2.
- Timeout: MAX_HOLD = 4, req[1] held forever while req[2] rises:
  - gnt = 4'b0010 for exactly 4 cycles;
  - expired pulses once;
  - gnt = 4'b0100 follows after GAP + IDLE.
- Simultaneous release and timeout: req[idx] drops on the cycle hold_cnt = MAX_HOLD-1. The block exits with expired = 0.
- Async reset mid-GRANT: reset asserted between edges drives gnt and busy to 0 before the next edge. After release, ptr = 0.
